// File: rtl/regport_sequencer.sv
// -----------------------------------------------------------------------------
// regport_sequencer
//
// Sequences every access to a single-ported register file that has registered
// read data. Each access cycle carries either one write or one dual read,
// never both. Writebacks are queued in an in-order write buffer. A read is
// presented to the register file in RD, its data is captured in CAP, and it is
// held as a response in RESP until the consumer accepts it.
//
// Optional feature (compile-time macro REGPORT_BYPASS_EN):
//   undefined : the write buffer is drained before any read is accepted.
//   defined   : reads take priority over draining. Each operand is forwarded
//               from the youngest matching write that was already buffered
//               when the read was accepted.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   rd_req_* / rd_addr_a/b   operand read request (valid/ready)
//   rd_rsp_* / rd_rsp_a/b    operand read response (valid/ready), held stable
//   wr_* / wr_addr/wr_data   writeback request (valid/ready)
//   rf_in_reg, rf_addr_a/b   register-file write data and addresses
//   rf_rw, rf_sel            register-file direction (1 read) and select
//                            (active low)
//   rf_out_a/b               register-file registered read data
// -----------------------------------------------------------------------------
module regport_sequencer #(
  parameter int WBUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req_valid,
  output logic        rd_req_ready,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic        rd_rsp_valid,
  input  logic        rd_rsp_ready,
  output logic [31:0] rd_rsp_a,
  output logic [31:0] rd_rsp_b,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rf_in_reg,
  output logic [4:0]  rf_addr_a,
  output logic [4:0]  rf_addr_b,
  output logic        rf_rw,
  output logic        rf_sel,
  input  logic [31:0] rf_out_a,
  input  logic [31:0] rf_out_b
);

  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WBUF_DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t           state_r;
  logic [4:0]       wbuf_addr_r [WBUF_DEPTH];
  logic [31:0]      wbuf_data_r [WBUF_DEPTH];
  logic [PTR_W-1:0] head_r;
  logic [PTR_W-1:0] tail_r;
  logic [CNT_W-1:0] count_r;
  logic [4:0]       lat_a_r;
  logic [4:0]       lat_b_r;
  logic [31:0]      rsp_a_r;
  logic [31:0]      rsp_b_r;
`ifdef REGPORT_BYPASS_EN
  // Number of entries that were already buffered when the read was accepted
  logic [CNT_W-1:0] snap_cnt_r;
`endif

  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        push_s;
  logic        pop_s;
  logic        rd_sel_s;
  logic        wr_sel_s;
  logic        rd_accept_s;
  logic [31:0] cap_a_s;
  logic [31:0] cap_b_s;

  assign rd_rsp_a = rsp_a_r;
  assign rd_rsp_b = rsp_b_r;

  // Arbitration between reads and draining, plus the handshake strobes
  always_comb begin
    fifo_empty_s = (count_r == {CNT_W{1'b0}});
    fifo_full_s  = (count_r == FULL_CNT);
`ifdef REGPORT_BYPASS_EN
    rd_sel_s = 1'b1;
    wr_sel_s = !fifo_empty_s && !rd_req_valid;
`else
    rd_sel_s = fifo_empty_s;
    wr_sel_s = !fifo_empty_s;
`endif
    rd_req_ready = (state_r == IDLE) && rd_sel_s;
    rd_accept_s  = rd_req_ready && rd_req_valid;
    wr_ready     = !fifo_full_s;
    // A push never depends on a same-cycle pop: a full buffer refuses the write
    push_s       = wr_valid && !fifo_full_s;
    pop_s        = (state_r == WR);
    rd_rsp_valid = (state_r == RESP);
  end

  // Data captured in CAP: register-file output, optionally overridden by a buffered write
  always_comb begin
    cap_a_s = rf_out_a;
    cap_b_s = rf_out_b;
`ifdef REGPORT_BYPASS_EN
    // Scan oldest to youngest so the youngest matching snapshotted entry wins.
    // The buffer is not popped between acceptance and CAP, so head_r still
    // points at the oldest snapshotted entry.
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      cap_a_s = ((CNT_W'(i) < snap_cnt_r) && (wbuf_addr_r[head_r + PTR_W'(i)] == lat_a_r))
                ? wbuf_data_r[head_r + PTR_W'(i)] : cap_a_s;
      cap_b_s = ((CNT_W'(i) < snap_cnt_r) && (wbuf_addr_r[head_r + PTR_W'(i)] == lat_b_r))
                ? wbuf_data_r[head_r + PTR_W'(i)] : cap_b_s;
    end
`endif
  end

  // Register-file drive decoded from the registered state
  always_comb begin
    rf_sel    = 1'b1;
    rf_rw     = 1'b0;
    rf_addr_a = 5'd0;
    rf_addr_b = 5'd0;
    rf_in_reg = 32'd0;
    case (state_r)
      WR: begin
        rf_sel    = 1'b0;
        rf_rw     = 1'b0;
        rf_addr_a = wbuf_addr_r[head_r];
        rf_in_reg = wbuf_data_r[head_r];
      end
      RD: begin
        rf_sel    = 1'b0;
        rf_rw     = 1'b1;
        rf_addr_a = lat_a_r;
        rf_addr_b = lat_b_r;
      end
      default: begin
        rf_sel = 1'b1;
      end
    endcase
  end

  // Access sequencer: state, latched read addresses and the response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      lat_a_r <= 5'd0;
      lat_b_r <= 5'd0;
      rsp_a_r <= 32'd0;
      rsp_b_r <= 32'd0;
`ifdef REGPORT_BYPASS_EN
      snap_cnt_r <= {CNT_W{1'b0}};
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (rd_accept_s) begin
            state_r <= RD;
            lat_a_r <= rd_addr_a;
            lat_b_r <= rd_addr_b;
`ifdef REGPORT_BYPASS_EN
            // count_r does not yet include a push made in this same cycle
            snap_cnt_r <= count_r;
`endif
          end else if (wr_sel_s) begin
            state_r <= WR;
          end else begin
            state_r <= IDLE;
          end
        end
        WR:   state_r <= IDLE;
        RD:   state_r <= CAP;
        CAP: begin
          rsp_a_r <= cap_a_s;
          rsp_b_r <= cap_b_s;
          state_r <= RESP;
        end
        RESP: begin
          if (rd_rsp_ready) begin
            state_r <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Write-buffer pointers and occupancy; reset discards every buffered write
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r  <= {PTR_W{1'b0}};
      tail_r  <= {PTR_W{1'b0}};
      count_r <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        tail_r <= tail_r + PTR_W'(1);
      end
      if (pop_s) begin
        head_r <= head_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

  // Write-buffer storage; contents are meaningless until written, so no reset
  always_ff @(posedge clk) begin
    if (push_s) begin
      wbuf_addr_r[tail_r] <= wr_addr;
      wbuf_data_r[tail_r] <= wr_data;
    end
  end

endmodule

// File: tb/tb_regport_sequencer.sv
// -----------------------------------------------------------------------------
// tb_regport_sequencer
//
// Drives regport_sequencer against a behavioural register-file model (one
// access per cycle, registered read data). Directed steps cover reset, basic
// read/write, read latency, buffer fill, same-cycle ordering, response
// backpressure, forwarding (REGPORT_BYPASS_EN builds) and mid-read reset.
// A randomized phase follows. It is checked against a reference array in
// which a read returns every write accepted strictly before the read's
// acceptance cycle.
// -----------------------------------------------------------------------------
module tb_regport_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_req_valid, rd_req_ready;
  logic [4:0]  rd_addr_a, rd_addr_b;
  logic        rd_rsp_valid, rd_rsp_ready;
  logic [31:0] rd_rsp_a, rd_rsp_b;
  logic        wr_valid, wr_ready;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] rf_in_reg;
  logic [4:0]  rf_addr_a, rf_addr_b;
  logic        rf_rw, rf_sel;
  logic [31:0] rf_out_a = 32'd0;
  logic [31:0] rf_out_b = 32'd0;

  always #5 clk = ~clk;

  regport_sequencer #(.WBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_ready(rd_rsp_ready),
    .rd_rsp_a(rd_rsp_a), .rd_rsp_b(rd_rsp_b),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_in_reg(rf_in_reg), .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
    .rf_rw(rf_rw), .rf_sel(rf_sel),
    .rf_out_a(rf_out_a), .rf_out_b(rf_out_b)
  );

  // Register-file model with a log of every write that reaches it
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  logic [4:0]  log_addr [$];
  logic [31:0] log_data [$];

  always @(posedge clk) begin
    if (!rf_sel) begin
      if (rf_rw) begin
        rf_out_a <= rf_mem[rf_addr_a];
        rf_out_b <= rf_mem[rf_addr_b];
      end else begin
        rf_mem[rf_addr_a] <= rf_in_reg;
        log_addr.push_back(rf_addr_a);
        log_data.push_back(rf_in_reg);
      end
    end
  end

  // Reference register contents as seen by a newly accepted read
  logic [31:0] ref_rf [32] = '{default: 32'h0};
  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    int n;
    n = 0;
    wr_valid = 1'b1; wr_addr = a; wr_data = d;
    while (!wr_ready && n < 50) begin tick(); n++; end
    check("wr_accept", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    ref_rf[a] = d;
  endtask

  // Called in the cycle after acceptance; lat counts cycles since acceptance
  task automatic wait_rsp(output logic [31:0] ra, output logic [31:0] rb, output int lat);
    lat = 1;
    while (!rd_rsp_valid && lat < 50) begin tick(); lat++; end
    check("rsp_arrive", 32'(rd_rsp_valid), 32'd1);
    ra = rd_rsp_a; rb = rd_rsp_b;
    rd_rsp_ready = 1'b1;
    tick();
    rd_rsp_ready = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, input logic [4:0] b,
                    output logic [31:0] ra, output logic [31:0] rb, output int lat);
    int n;
    n = 0;
    rd_req_valid = 1'b1; rd_addr_a = a; rd_addr_b = b; rd_rsp_ready = 1'b1;
    while (!rd_req_ready && n < 50) begin tick(); n++; end
    check("rd_accept", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    wait_rsp(ra, rb, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb, hold_a, hold_b, exp_a, exp_b;
    int lat, base, n, cyc;
    bit wr_pend, rd_busy, rd_acc, wr_acc, gen;

    rst = 1'b1; rd_req_valid = 1'b0; rd_addr_a = 5'd0; rd_addr_b = 5'd0;
    rd_rsp_ready = 1'b0; wr_valid = 1'b0; wr_addr = 5'd0; wr_data = 32'd0;
    tick(); tick();

    // Reset state
    check("rst_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("rst_rd_req_ready", 32'(rd_req_ready), 32'd1);
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_rf_sel", 32'(rf_sel), 32'd1);
    check("rst_rf_rw", 32'(rf_rw), 32'd0);
    check("rst_rf_addr_a", 32'(rf_addr_a), 32'd0);
    check("rst_rf_addr_b", 32'(rf_addr_b), 32'd0);
    check("rst_rf_in_reg", rf_in_reg, 32'd0);
    check("rst_rsp_a", rd_rsp_a, 32'd0);
    check("rst_rsp_b", rd_rsp_b, 32'd0);
    rst = 1'b0;

    // Basic write then dual read
    wr(5'd0, 32'h0000_0000);
    wr(5'd5, 32'h1234_5678);
    rd(5'd5, 5'd0, ra, rb, lat);
    check("basic_rsp_a", ra, 32'h1234_5678);
    check("basic_rsp_b", rb, 32'h0000_0000);

    // Latency with an empty buffer
    repeat (6) tick();
    rd(5'd5, 5'd5, ra, rb, lat);
    check("rd_latency", 32'(lat), 32'd3);
    check("latency_rsp_a", ra, 32'h1234_5678);

    // Buffer fill: three back-to-back writes
    repeat (2) tick();
    base = log_addr.size();
    wr_valid = 1'b1; wr_addr = 5'd10; wr_data = 32'hA0A0_0001;
    check("fill_ready_1", 32'(wr_ready), 32'd1);
    tick();
    wr_addr = 5'd11; wr_data = 32'hA0A0_0002;
    check("fill_ready_2", 32'(wr_ready), 32'd1);
    tick();
    wr_addr = 5'd12; wr_data = 32'hA0A0_0003;
    check("fill_ready_3_low", 32'(wr_ready), 32'd0);
    n = 0;
    while (!wr_ready && n < 50) begin tick(); n++; end
    check("fill_third_accept", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    ref_rf[10] = 32'hA0A0_0001; ref_rf[11] = 32'hA0A0_0002; ref_rf[12] = 32'hA0A0_0003;
    repeat (10) tick();
    check("fill_write_count", 32'(log_addr.size() - base), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (log_addr.size() > base + k) begin
        check("fill_order_addr", 32'(log_addr[base + k]), 32'(10 + k));
        check("fill_order_data", log_data[base + k], 32'hA0A0_0001 + 32'(k));
      end
    end

    // Same-cycle write and read: the read sees the old value
    wr(5'd3, 32'h0000_0001);
    repeat (6) tick();
    rd_req_valid = 1'b1; rd_addr_a = 5'd3; rd_addr_b = 5'd3; rd_rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd3; wr_data = 32'hAAAA_0000;
    check("same_cycle_rd_ready", 32'(rd_req_ready), 32'd1);
    check("same_cycle_wr_ready", 32'(wr_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0; wr_valid = 1'b0;
    wait_rsp(ra, rb, lat);
    ref_rf[3] = 32'hAAAA_0000;
    check("same_cycle_old_a", ra, 32'h0000_0001);
    check("same_cycle_old_b", rb, 32'h0000_0001);
    rd(5'd3, 5'd3, ra, rb, lat);
    check("later_read_new_a", ra, 32'hAAAA_0000);

    // Response backpressure: data held, no new read accepted
    repeat (6) tick();
    rd_req_valid = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd10; rd_rsp_ready = 1'b0;
    check("bp_rd_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    n = 0;
    while (!rd_rsp_valid && n < 50) begin tick(); n++; end
    hold_a = rd_rsp_a; hold_b = rd_rsp_b;
    check("bp_first_a", hold_a, ref_rf[5]);
    check("bp_first_b", hold_b, ref_rf[10]);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid_held", 32'(rd_rsp_valid), 32'd1);
      check("bp_data_a_stable", rd_rsp_a, ref_rf[5]);
      check("bp_data_b_stable", rd_rsp_b, ref_rf[10]);
      check("bp_rd_req_ready_low", 32'(rd_req_ready), 32'd0);
      tick();
    end
    rd_rsp_ready = 1'b1;
    tick();
    rd_rsp_ready = 1'b0;
    check("bp_released", 32'(rd_rsp_valid), 32'd0);

`ifdef REGPORT_BYPASS_EN
    // Two writes to r7 buffered while a read is in flight, then a read of r7
    // is accepted before the buffer drains
    repeat (6) tick();
    base = log_addr.size();
    rd_req_valid = 1'b1; rd_addr_a = 5'd0; rd_addr_b = 5'd0; rd_rsp_ready = 1'b0;
    tick();
    rd_req_valid = 1'b0;
    wr_valid = 1'b1; wr_addr = 5'd7; wr_data = 32'h0000_0001;
    check("byp_wr1_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_data = 32'h0000_0002;
    check("byp_wr2_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    ref_rf[7] = 32'h0000_0002;
    n = 0;
    while (!rd_rsp_valid && n < 50) begin tick(); n++; end
    rd_rsp_ready = 1'b1;
    rd_req_valid = 1'b1; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    tick();
    rd_rsp_ready = 1'b0;
    check("byp_rd_ready", 32'(rd_req_ready), 32'd1);
    check("byp_no_drain_yet", 32'(log_addr.size() - base), 32'd0);
    tick();
    rd_req_valid = 1'b0;
    wait_rsp(ra, rb, lat);
    check("byp_fwd_a", ra, 32'h0000_0002);
    check("byp_fwd_b", rb, 32'h0000_0002);
`endif

    // Reset during CAP with two buffered writes
    repeat (10) tick();
    base = log_addr.size();
    rd_req_valid = 1'b1; rd_addr_a = 5'd5; rd_addr_b = 5'd5; rd_rsp_ready = 1'b1;
    wr_valid = 1'b1; wr_addr = 5'd20; wr_data = 32'hDEAD_0020;
    check("rstcap_rd_ready", 32'(rd_req_ready), 32'd1);
    tick();
    rd_req_valid = 1'b0;
    wr_addr = 5'd21; wr_data = 32'hDEAD_0021;
    check("rstcap_wr2_ready", 32'(wr_ready), 32'd1);
    tick();
    wr_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstcap_rsp_valid", 32'(rd_rsp_valid), 32'd0);
    check("rstcap_rf_sel", 32'(rf_sel), 32'd1);
    check("rstcap_rd_req_ready", 32'(rd_req_ready), 32'd1);
    check("rstcap_wr_ready", 32'(wr_ready), 32'd1);
    check("rstcap_rsp_a", rd_rsp_a, 32'd0);
    repeat (10) tick();
    check("rstcap_writes_discarded", 32'(log_addr.size() - base), 32'd0);

    // Randomized concurrent traffic against the reference array
    wr_pend = 1'b0; rd_busy = 1'b0; exp_a = 32'd0; exp_b = 32'd0;
    rd_rsp_ready = 1'b0;
    for (cyc = 0; cyc < 1600; cyc++) begin
      gen = (cyc < 1500);
      if (gen && !wr_pend && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b1; wr_addr = 5'($urandom); wr_data = $urandom; wr_pend = 1'b1;
      end
      if (gen && !rd_busy && $urandom_range(0, 3) == 0) begin
        rd_req_valid = 1'b1; rd_addr_a = 5'($urandom); rd_addr_b = 5'($urandom);
        rd_busy = 1'b1;
      end
      rd_rsp_ready = (!gen || $urandom_range(0, 1) == 1) ? 1'b1 : 1'b0;
      rd_acc = rd_req_valid && rd_req_ready;
      wr_acc = wr_valid && wr_ready;
      if (rd_acc) begin
        exp_a = ref_rf[rd_addr_a];
        exp_b = ref_rf[rd_addr_b];
      end
      if (rd_rsp_valid && rd_rsp_ready) begin
        check("rand_rsp_a", rd_rsp_a, exp_a);
        check("rand_rsp_b", rd_rsp_b, exp_b);
        rd_busy = 1'b0;
      end
      if (wr_acc) ref_rf[wr_addr] = wr_data;
      tick();
      if (rd_acc) rd_req_valid = 1'b0;
      if (wr_acc) begin wr_valid = 1'b0; wr_pend = 1'b0; end
    end
    rd_rsp_ready = 1'b0;
    check("rand_rd_drained", 32'(rd_busy), 32'd0);
    check("rand_wr_drained", 32'(wr_pend), 32'd0);

    // Final sweep of the whole register file
    for (int k = 0; k < 16; k++) begin
      rd(5'(k), 5'(k + 16), ra, rb, lat);
      check("sweep_a", ra, ref_rf[k]);
      check("sweep_b", rb, ref_rf[k + 16]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
